alu_issue_select: RTL and testbench

- Issue scheduler for the ALU reservation-station array. Each cycle it selects up to two operand-ready entries, oldest first, and grants them to ALU0/ALU1 according to alu_rdy.
- Keeps an RS_SIZE x RS_SIZE age matrix, updated on every allocation from dispatch.
- Pulses a grant to the chosen stations and presents registered issue slots to execute.

---
 rtl/alu_issue_select_if.sv | 29 ++
 rtl/alu_issue_select.sv | 145 ++++++++++++++
 tb/tb_alu_issue_select.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_select_if.sv
// Bundle between the ALU reservation stations and the issue scheduler.
// The master side (reservation stations / dispatch) drives occupancy, readiness and
// allocation strobes. The slave side (scheduler) returns grants and issue slots.
interface alu_issue_select_if #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W   = $clog2(RS_SIZE)
);
  logic               flush;
  logic               cache_stall;
  logic [RS_SIZE-1:0] alloc_we;
  logic [RS_SIZE-1:0] alloc_slot;
  logic [RS_SIZE-1:0] entry_valid;
  logic [RS_SIZE-1:0] entry_ready;
  logic [1:0]         alu_rdy;
  logic [RS_SIZE-1:0] issue_grant;
  logic [1:0]         issue_valid;
  logic [IDX_W-1:0]   issue_idx0;
  logic [IDX_W-1:0]   issue_idx1;

  modport master (
    output flush, cache_stall, alloc_we, alloc_slot, entry_valid, entry_ready, alu_rdy,
    input  issue_grant, issue_valid, issue_idx0, issue_idx1
  );

  modport slave (
    input  flush, cache_stall, alloc_we, alloc_slot, entry_valid, entry_ready, alu_rdy,
    output issue_grant, issue_valid, issue_idx0, issue_idx1
  );
endinterface

// File: rtl/alu_issue_select.sv
// Oldest-first dual issue select for the ALU reservation stations.
// An age matrix (age_reg[i][j] = 1 : entry i older than j) is maintained on
// allocation; each cycle the two oldest ready entries are granted to the ALUs.
module alu_issue_select #(
  parameter int RS_SIZE = 8,
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input  logic               clk,
  input  logic               rst,   // asynchronous, active-low
  alu_issue_select_if.slave  bus
);

  localparam int N = RS_SIZE;

  logic [N-1:0][N-1:0] age_reg;
  logic [N-1:0][N-1:0] age_next;
  logic [N-1:0][N-1:0] age_col;    // age_col[i][j] = age_reg[j][i]: j older than i
  logic [N-1:0]        cand;
  logic [N-1:0]        cand_b;
  logic [N-1:0]        free_a;
  logic [N-1:0]        free_b;
  logic                a_vld;
  logic                b_vld;
  logic [IDX_W-1:0]    a_idx;
  logic [IDX_W-1:0]    b_idx;
  logic                grant_en;
  logic                take0;
  logic                take1;
  logic [IDX_W-1:0]    idx1_sel;
  logic [N-1:0]        grant;
  logic [1:0]          issue_valid_reg;
  logic [IDX_W-1:0]    issue_idx0_reg;
  logic [IDX_W-1:0]    issue_idx1_reg;

  // Lowest set bit; with a consistent age order at most one bit is ever set,
  // so this only acts as a cheap encoder plus a deterministic fallback.
  function automatic logic [IDX_W:0] first_set(input logic [N-1:0] v);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  assign cand = bus.entry_valid & bus.entry_ready;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_bit
        assign age_col[gi][gj] = age_reg[gj][gi];
        if (gi == gj) begin : g_diag
          assign age_next[gi][gj] = 1'b0;
        end else begin : g_off
          // Co-allocated pair: slot 0 beats slot 1, otherwise lower index is older.
          localparam bit LOWER = (gi < gj);
          logic pair_older;
          assign pair_older = (!bus.alloc_slot[gi] && bus.alloc_slot[gj]) ||
                              ((bus.alloc_slot[gi] == bus.alloc_slot[gj]) && LOWER);
          assign age_next[gi][gj] =
              bus.flush            ? 1'b0 :
              bus.cache_stall      ? age_reg[gi][gj] :
              bus.alloc_we[gi]     ? (bus.alloc_we[gj] & pair_older) :
              bus.alloc_we[gj]     ? (bus.entry_valid[gi] & ~grant[gi]) :
                                     (age_reg[gi][gj] & ~grant[gi] & ~grant[gj]);
        end
      end
      // Entry is selectable when no other candidate in the same pool is older.
      assign free_a[gi] = cand[gi]   & ~|(cand   & age_col[gi]);
      assign free_b[gi] = cand_b[gi] & ~|(cand_b & age_col[gi]);
    end
  endgenerate

  // Pick A is the oldest candidate; pick B pool is the candidates minus A.
  always_comb begin
    {a_vld, a_idx} = first_set(free_a);
    cand_b         = cand & ~(a_vld ? (N'(1) << a_idx) : '0);
  end

  // Pick B: oldest candidate once A is taken out.
  always_comb begin
    {b_vld, b_idx} = first_set(free_b);
  end

  // Route picks onto the ALUs and build the one-hot grant vector.
  always_comb begin
    grant_en = rst & ~bus.flush & ~bus.cache_stall;
    take0    = grant_en & bus.alu_rdy[0] & a_vld;
    take1    = grant_en & bus.alu_rdy[1] & (bus.alu_rdy[0] ? b_vld : a_vld);
    idx1_sel = bus.alu_rdy[0] ? b_idx : a_idx;
    grant    = '0;
    if (take0) grant[a_idx]    = 1'b1;
    if (take1) grant[idx1_sel] = 1'b1;
  end

  assign bus.issue_grant = grant;
  assign bus.issue_valid = issue_valid_reg;
  assign bus.issue_idx0  = issue_idx0_reg;
  assign bus.issue_idx1  = issue_idx1_reg;

  // Age matrix register; flush/stall/allocation effects live in age_next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) age_reg <= '0;
    else      age_reg <= age_next;
  end

  // Issue slots: capture this cycle's grants, held across a stall, dropped by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid_reg <= 2'b00;
      issue_idx0_reg  <= '0;
      issue_idx1_reg  <= '0;
    end else if (bus.flush) begin
      issue_valid_reg <= 2'b00;
    end else if (!bus.cache_stall) begin
      issue_valid_reg <= {take1, take0};
      if (take0) issue_idx0_reg <= a_idx;
      if (take1) issue_idx1_reg <= idx1_sel;
    end
  end

  // Valid entries must form a strict total order: antisymmetric, total, transitive.
  function automatic logic order_ok(input logic [N-1:0][N-1:0] m, input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (m[i][i]) return 1'b0;
      for (int j = 0; j < N; j++) begin
        if (v[i] && v[j] && i != j) begin
          if (m[i][j] == m[j][i]) return 1'b0;
          for (int k = 0; k < N; k++) begin
            if (v[k] && m[i][j] && m[j][k] && !m[i][k]) return 1'b0;
          end
        end
      end
    end
    return 1'b1;
  endfunction

  a_alloc_free: assert property (@(posedge clk) disable iff (!rst)
    ((bus.alloc_we & bus.entry_valid & ~grant) == '0));

  a_age_order: assert property (@(posedge clk) disable iff (!rst)
    order_ok(age_reg, bus.entry_valid));

endmodule

// File: tb/tb_alu_issue_select.sv
// Directed bench for alu_issue_select. The bench plays the reservation-station
// array: it keeps entry_valid itself (set on allocation, cleared on grant/flush).
module tb_alu_issue_select;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_issue_select_if #(.RS_SIZE(8)) bus ();

  alu_issue_select #(.RS_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample this cycle's grant/allocation, clock, then update the RS occupancy model.
  task automatic step();
    logic [7:0] g;
    logic [7:0] al;
    logic       fl;
    logic       st;
    #1;
    g  = bus.issue_grant;
    al = bus.alloc_we;
    fl = bus.flush;
    st = bus.cache_stall;
    @(posedge clk);
    #1;
    if (fl)       bus.entry_valid = 8'h00;
    else if (!st) bus.entry_valid = (bus.entry_valid & ~g) | al;
    bus.alloc_we   = 8'h00;
    bus.alloc_slot = 8'h00;
    #1;
    $display("[%0t] grant=%b valid_entries=%b issue_valid=%b idx0=%0d idx1=%0d",
             $time, g, bus.entry_valid, bus.issue_valid, bus.issue_idx0, bus.issue_idx1);
  endtask

  task automatic alloc(input int idx, input logic slot);
    bus.alloc_we[idx]   = 1'b1;
    bus.alloc_slot[idx] = slot;
  endtask

  task automatic test_reset();
    bus.entry_valid = 8'h0F;
    bus.entry_ready = 8'hFF;
    bus.alu_rdy     = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.issue_grant !== 8'h00) begin n_err++; $display("FAIL reset_grant: got %b exp %b", bus.issue_grant, 8'h00); end
    n_cmp++; if (bus.issue_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b exp 00", bus.issue_valid); end
    n_cmp++; if (bus.issue_idx0 !== 3'd0) begin n_err++; $display("FAIL reset_idx0: got %0d exp 0", bus.issue_idx0); end
    n_cmp++; if (bus.issue_idx1 !== 3'd0) begin n_err++; $display("FAIL reset_idx1: got %0d exp 0", bus.issue_idx1); end
    bus.entry_valid = 8'h00;
    bus.alu_rdy     = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_oldest_first();
    bus.alu_rdy = 2'b00;
    bus.entry_ready = 8'hFF;
    alloc(3, 1'b0); step();
    alloc(5, 1'b0); step();
    alloc(1, 1'b0); step();
    bus.alu_rdy = 2'b11; #1;
    n_cmp++; if (bus.issue_grant !== 8'b0010_1000) begin n_err++; $display("FAIL oldest_grant_35: got %b exp 00101000", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_valid !== 2'b11) begin n_err++; $display("FAIL oldest_valid: got %b exp 11", bus.issue_valid); end
    n_cmp++; if (bus.issue_idx0 !== 3'd3) begin n_err++; $display("FAIL oldest_idx0: got %0d exp 3", bus.issue_idx0); end
    n_cmp++; if (bus.issue_idx1 !== 3'd5) begin n_err++; $display("FAIL oldest_idx1: got %0d exp 5", bus.issue_idx1); end
    n_cmp++; if (bus.issue_grant !== 8'h02) begin n_err++; $display("FAIL oldest_grant_1: got %b exp 00000010", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_valid !== 2'b01) begin n_err++; $display("FAIL oldest_valid_1: got %b exp 01", bus.issue_valid); end
    n_cmp++; if (bus.issue_idx0 !== 3'd1) begin n_err++; $display("FAIL oldest_idx0_1: got %0d exp 1", bus.issue_idx0); end
    n_cmp++; if (bus.issue_grant !== 8'h00) begin n_err++; $display("FAIL empty_grant: got %b exp 00000000", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_valid !== 2'b00) begin n_err++; $display("FAIL empty_valid: got %b exp 00", bus.issue_valid); end
  endtask

  task automatic test_same_cycle_pair();
    bus.alu_rdy = 2'b10;
    alloc(2, 1'b1);
    alloc(6, 1'b0);
    #1;
    n_cmp++; if (bus.issue_grant !== 8'h00) begin n_err++; $display("FAIL pair_alloc_grant: got %b exp 00000000", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_grant !== 8'h40) begin n_err++; $display("FAIL pair_grant_6: got %b exp 01000000", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_valid !== 2'b10) begin n_err++; $display("FAIL pair_valid: got %b exp 10", bus.issue_valid); end
    n_cmp++; if (bus.issue_idx1 !== 3'd6) begin n_err++; $display("FAIL pair_idx1: got %0d exp 6", bus.issue_idx1); end
    n_cmp++; if (bus.issue_grant !== 8'h04) begin n_err++; $display("FAIL pair_grant_2: got %b exp 00000100", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_idx1 !== 3'd2) begin n_err++; $display("FAIL pair_idx1_2: got %0d exp 2", bus.issue_idx1); end
    n_cmp++; if (bus.issue_valid !== 2'b10) begin n_err++; $display("FAIL pair_valid_2: got %b exp 10", bus.issue_valid); end
    step();
    n_cmp++; if (bus.issue_valid !== 2'b00) begin n_err++; $display("FAIL pair_drain: got %b exp 00", bus.issue_valid); end
  endtask

  task automatic test_not_ready_oldest();
    bus.alu_rdy = 2'b00;
    bus.entry_ready = 8'h90;
    alloc(0, 1'b0); step();
    alloc(4, 1'b0); step();
    alloc(7, 1'b0); step();
    bus.alu_rdy = 2'b11; #1;
    n_cmp++; if (bus.issue_grant !== 8'h90) begin n_err++; $display("FAIL skip_grant: got %b exp 10010000", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_idx0 !== 3'd4) begin n_err++; $display("FAIL skip_idx0: got %0d exp 4", bus.issue_idx0); end
    n_cmp++; if (bus.issue_idx1 !== 3'd7) begin n_err++; $display("FAIL skip_idx1: got %0d exp 7", bus.issue_idx1); end
    bus.alu_rdy = 2'b00;
    bus.entry_ready = 8'h94;
    alloc(2, 1'b0);
    step();
    bus.entry_ready = 8'h05;
    bus.alu_rdy = 2'b01; #1;
    n_cmp++; if (bus.issue_grant !== 8'h01) begin n_err++; $display("FAIL late_ready_grant: got %b exp 00000001", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_idx0 !== 3'd0) begin n_err++; $display("FAIL late_ready_idx0: got %0d exp 0", bus.issue_idx0); end
    n_cmp++; if (bus.issue_grant !== 8'h04) begin n_err++; $display("FAIL later_alloc_grant: got %b exp 00000100", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_idx0 !== 3'd2) begin n_err++; $display("FAIL later_alloc_idx0: got %0d exp 2", bus.issue_idx0); end
    step();
  endtask

  task automatic test_stall();
    bus.alu_rdy = 2'b00;
    bus.entry_ready = 8'hFF;
    for (int e = 1; e <= 4; e++) begin alloc(e, 1'b0); step(); end
    bus.alu_rdy = 2'b11; #1;
    n_cmp++; if (bus.issue_grant !== 8'h06) begin n_err++; $display("FAIL prestall_grant: got %b exp 00000110", bus.issue_grant); end
    step();
    bus.cache_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (bus.issue_grant !== 8'h00) begin n_err++; $display("FAIL stall_grant: got %b exp 00000000", bus.issue_grant); end
      step();
      n_cmp++; if (bus.issue_valid !== 2'b11) begin n_err++; $display("FAIL stall_valid: got %b exp 11", bus.issue_valid); end
      n_cmp++; if (bus.issue_idx0 !== 3'd1 || bus.issue_idx1 !== 3'd2) begin n_err++; $display("FAIL stall_idx: got %0d/%0d exp 1/2", bus.issue_idx0, bus.issue_idx1); end
    end
    bus.cache_stall = 1'b0; #1;
    n_cmp++; if (bus.issue_grant !== 8'h18) begin n_err++; $display("FAIL unstall_grant: got %b exp 00011000", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_idx0 !== 3'd3 || bus.issue_idx1 !== 3'd4) begin n_err++; $display("FAIL unstall_idx: got %0d/%0d exp 3/4", bus.issue_idx0, bus.issue_idx1); end
    step();
    n_cmp++; if (bus.issue_valid !== 2'b00) begin n_err++; $display("FAIL unstall_drain: got %b exp 00", bus.issue_valid); end
  endtask

  task automatic test_flush();
    bus.alu_rdy = 2'b00;
    bus.entry_ready = 8'hFF;
    alloc(0, 1'b0); step();
    alloc(6, 1'b0); step();
    alloc(7, 1'b0); step();
    bus.alu_rdy = 2'b11; #1;
    n_cmp++; if (bus.issue_grant !== 8'h41) begin n_err++; $display("FAIL preflush_grant: got %b exp 01000001", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_valid !== 2'b11) begin n_err++; $display("FAIL preflush_valid: got %b exp 11", bus.issue_valid); end
    bus.flush = 1'b1;
    bus.cache_stall = 1'b1;
    alloc(1, 1'b0); #1;
    n_cmp++; if (bus.issue_grant !== 8'h00) begin n_err++; $display("FAIL flush_grant: got %b exp 00000000", bus.issue_grant); end
    step();
    bus.flush = 1'b0;
    bus.cache_stall = 1'b0; #1;
    n_cmp++; if (bus.issue_valid !== 2'b00) begin n_err++; $display("FAIL flush_valid: got %b exp 00", bus.issue_valid); end
    n_cmp++; if (dut.age_reg !== 64'h0) begin n_err++; $display("FAIL flush_age: got %h exp 0", dut.age_reg); end
    bus.alu_rdy = 2'b01;
    alloc(5, 1'b0); step();
    n_cmp++; if (bus.issue_grant !== 8'h20) begin n_err++; $display("FAIL postflush_grant: got %b exp 00100000", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_valid !== 2'b01 || bus.issue_idx0 !== 3'd5) begin n_err++; $display("FAIL postflush_issue: got %b/%0d exp 01/5", bus.issue_valid, bus.issue_idx0); end
    step();
  endtask

  task automatic test_async_reset();
    bus.alu_rdy = 2'b00;
    bus.entry_ready = 8'hFF;
    for (int e = 2; e <= 5; e++) begin alloc(e, 1'b0); step(); end
    bus.alu_rdy = 2'b11;
    step();
    n_cmp++; if (bus.issue_grant !== 8'h30) begin n_err++; $display("FAIL prereset_grant: got %b exp 00110000", bus.issue_grant); end
    n_cmp++; if (bus.issue_valid !== 2'b11) begin n_err++; $display("FAIL prereset_valid: got %b exp 11", bus.issue_valid); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.issue_grant !== 8'h00) begin n_err++; $display("FAIL arst_grant: got %b exp 00000000", bus.issue_grant); end
    n_cmp++; if (bus.issue_valid !== 2'b00) begin n_err++; $display("FAIL arst_valid: got %b exp 00", bus.issue_valid); end
    n_cmp++; if (bus.issue_idx0 !== 3'd0 || bus.issue_idx1 !== 3'd0) begin n_err++; $display("FAIL arst_idx: got %0d/%0d exp 0/0", bus.issue_idx0, bus.issue_idx1); end
    n_cmp++; if (dut.age_reg !== 64'h0) begin n_err++; $display("FAIL arst_age: got %h exp 0", dut.age_reg); end
    bus.entry_valid = 8'h00;
    bus.alu_rdy = 2'b01;
    #1;
    rst = 1'b1;
    alloc(6, 1'b0);
    step();
    n_cmp++; if (bus.issue_grant !== 8'h40) begin n_err++; $display("FAIL postreset_grant: got %b exp 01000000", bus.issue_grant); end
    step();
    n_cmp++; if (bus.issue_valid !== 2'b01 || bus.issue_idx0 !== 3'd6) begin n_err++; $display("FAIL postreset_issue: got %b/%0d exp 01/6", bus.issue_valid, bus.issue_idx0); end
  endtask

  initial begin
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.cache_stall = 1'b0;
    bus.alloc_we = 8'h00;
    bus.alloc_slot = 8'h00;
    bus.entry_valid = 8'h00;
    bus.entry_ready = 8'h00;
    bus.alu_rdy = 2'b00;
    test_reset();
    test_oldest_first();
    test_same_cycle_pair();
    test_not_ready_oldest();
    test_stall();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
